// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of the shared memory unit
// One access in flight at a time; a watchdog turns a hung access into an error completion.

`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 20
`endif

module mem_arbiter #(
  parameter int ADDR_W  = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W  = `MEMORY_DATA_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic              req0_valid,
  input  logic [1:0]        req0_func,
  input  logic [ADDR_W-1:0] req0_addr0,
  input  logic [ADDR_W-1:0] req0_addr1,
  input  logic              req1_valid,
  input  logic [1:0]        req1_func,
  input  logic [ADDR_W-1:0] req1_addr0,
  input  logic [ADDR_W-1:0] req1_addr1,
  output logic              req0_ack,
  output logic              req1_ack,
  output logic              req0_done,
  output logic              req1_done,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        mem_func,
  output logic              mem_execute,
  output logic [ADDR_W-1:0] mem_addr0,
  output logic [ADDR_W-1:0] mem_addr1,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // The first WAIT cycle is the earliest legal ready, so the watchdog grants
  // TIMEOUT cycles beyond it; done with error lands TIMEOUT+2 cycles after ack.
  localparam logic [7:0] TIMER_LIMIT = 8'(TIMEOUT);

  state_t     state;
  logic       last_grant;
  logic [7:0] timer;
  logic       pick1;

  always_comb begin
    pick1 = req1_valid && (!req0_valid || !last_grant);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      timer       <= '0;
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
      mem_func    <= '0;
      mem_execute <= 1'b0;
      mem_addr0   <= '0;
      mem_addr1   <= '0;
    end else begin
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      mem_execute <= 1'b0;
      case (state)
        IDLE: begin
          if (power && (req0_valid || req1_valid)) begin
            if (pick1) begin
              mem_func  <= req1_func;
              mem_addr0 <= req1_addr0;
              mem_addr1 <= req1_addr1;
              req1_ack  <= 1'b1;
            end else begin
              mem_func  <= req0_func;
              mem_addr0 <= req0_addr0;
              mem_addr1 <= req0_addr1;
              req0_ack  <= 1'b1;
            end
            last_grant  <= pick1;
            mem_execute <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mem_ready) begin
            rsp_data  <= mem_data_out;
            rsp_addr  <= mem_addr_out;
            rsp_err   <= 1'b0;
            req0_done <= !last_grant;
            req1_done <= last_grant;
            state     <= IDLE;
          end else if (timer == TIMER_LIMIT) begin
            rsp_data  <= '0;
            rsp_addr  <= '0;
            rsp_err   <= 1'b1;
            req0_done <= !last_grant;
            req1_done <= last_grant;
            state     <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 20;
  localparam int TMO    = 8;
  localparam logic [1:0] GET_CONTENTS = 2'b00;

  logic              clk = 1'b0;
  logic              rst;
  logic              power;
  logic              req0_valid, req1_valid;
  logic [1:0]        req0_func, req1_func;
  logic [ADDR_W-1:0] req0_addr0, req0_addr1, req1_addr0, req1_addr1;
  logic              req0_ack, req1_ack, req0_done, req1_done, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic [1:0]        mem_func;
  logic              mem_execute;
  logic [ADDR_W-1:0] mem_addr0, mem_addr1;
  logic [DATA_W-1:0] mem_data_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_ready;
  logic              any_out;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign any_out = |{req0_ack, req1_ack, req0_done, req1_done, rsp_err, rsp_data,
                     rsp_addr, mem_func, mem_execute, mem_addr0, mem_addr1};

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .power(power),
    .req0_valid(req0_valid), .req0_func(req0_func), .req0_addr0(req0_addr0), .req0_addr1(req0_addr1),
    .req1_valid(req1_valid), .req1_func(req1_func), .req1_addr0(req1_addr0), .req1_addr1(req1_addr1),
    .req0_ack(req0_ack), .req1_ack(req1_ack), .req0_done(req0_done), .req1_done(req1_done),
    .rsp_err(rsp_err), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .mem_func(mem_func), .mem_execute(mem_execute), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_data_out(mem_data_out), .mem_addr_out(mem_addr_out), .mem_ready(mem_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; power = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_func = GET_CONTENTS; req1_func = 2'b01;
    req0_addr0 = '0; req0_addr1 = '0; req1_addr0 = '0; req1_addr1 = '0;
    mem_data_out = '0; mem_addr_out = '0; mem_ready = 1'b0;
    tick(); tick();
    total++; if (any_out !== 1'b0) $display("FAIL reset_outputs got %b exp 0", any_out); else passed++;
    rst = 1'b1;
    tick(); tick();
    total++; if (any_out !== 1'b0) $display("FAIL idle_quiet got %b exp 0", any_out); else passed++;
  endtask

  task automatic test_single_read();
    req0_valid = 1'b1; req0_func = GET_CONTENTS; req0_addr0 = 16'd4; req0_addr1 = 16'd7;
    tick();
    total++; if ({req0_ack, req1_ack, mem_execute} !== 3'b101)
      $display("FAIL read_ack got %b exp 101", {req0_ack, req1_ack, mem_execute}); else passed++;
    total++; if ({mem_func, mem_addr0, mem_addr1} !== {GET_CONTENTS, 16'd4, 16'd7})
      $display("FAIL read_mem_args got %h exp %h", {mem_func, mem_addr0, mem_addr1}, {GET_CONTENTS, 16'd4, 16'd7}); else passed++;
    req0_valid = 1'b0; req0_addr0 = 16'd99;
    tick();
    total++; if ({mem_execute, req0_ack, req0_done, mem_addr0} !== {3'b000, 16'd4})
      $display("FAIL read_wait got %h exp %h", {mem_execute, req0_ack, req0_done, mem_addr0}, {3'b000, 16'd4}); else passed++;
    mem_ready = 1'b1; mem_data_out = 20'h00C00; mem_addr_out = 16'd4;
    tick();
    mem_ready = 1'b0;
    total++; if ({req0_done, req1_done, rsp_err} !== 3'b100)
      $display("FAIL read_done got %b exp 100", {req0_done, req1_done, rsp_err}); else passed++;
    total++; if ({rsp_data, rsp_addr} !== {20'h00C00, 16'd4})
      $display("FAIL read_data got %h exp %h", {rsp_data, rsp_addr}, {20'h00C00, 16'd4}); else passed++;
    mem_data_out = 20'h12345;
    tick();
    total++; if ({req0_done, rsp_data, mem_addr0} !== {1'b0, 20'h00C00, 16'd4})
      $display("FAIL read_hold got %h exp %h", {req0_done, rsp_data, mem_addr0}, {1'b0, 20'h00C00, 16'd4}); else passed++;
  endtask

  task automatic test_contention();
    rst = 1'b0; tick(); rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr0 = 16'h0A0; req1_addr0 = 16'h1B0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({req0_ack, req1_ack} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL contention_ack%0d got %b exp %b", i, {req0_ack, req1_ack}, (i % 2 == 0) ? 2'b10 : 2'b01); else passed++;
      if (i % 2 == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      tick();
      mem_ready = 1'b1; mem_data_out = 20'(i + 1); mem_addr_out = 16'(i);
      tick();
      mem_ready = 1'b0;
      total++; if ({req0_done, req1_done, rsp_data} !== {((i % 2 == 0) ? 2'b10 : 2'b01), 20'(i + 1)})
        $display("FAIL contention_done%0d got %h exp %h", i, {req0_done, req1_done, rsp_data}, {((i % 2 == 0) ? 2'b10 : 2'b01), 20'(i + 1)}); else passed++;
      if (i % 2 == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    req1_valid = 1'b1; req1_addr0 = 16'h55;
    tick();
    total++; if (req1_ack !== 1'b1) $display("FAIL timeout_ack got %b exp 1", req1_ack); else passed++;
    req1_valid = 1'b0;
    for (int n = 1; n < 10; n++) begin
      tick();
      if (req0_done || req1_done) early = 1'b1;
    end
    total++; if (early !== 1'b0) $display("FAIL timeout_early got %b exp 0", early); else passed++;
    tick();
    total++; if ({req1_done, req0_done, rsp_err, rsp_data, rsp_addr} !== {3'b101, 20'h0, 16'h0})
      $display("FAIL timeout_done got %h exp %h", {req1_done, req0_done, rsp_err, rsp_data, rsp_addr}, {3'b101, 20'h0, 16'h0}); else passed++;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    total++; if (req0_ack !== 1'b1) $display("FAIL after_timeout_ack got %b exp 1", req0_ack); else passed++;
    tick();
    mem_ready = 1'b1; mem_data_out = 20'hABCDE; mem_addr_out = 16'h0042;
    tick();
    mem_ready = 1'b0;
    total++; if ({req0_done, rsp_err, rsp_data} !== {2'b10, 20'hABCDE})
      $display("FAIL after_timeout_done got %h exp %h", {req0_done, rsp_err, rsp_data}, {2'b10, 20'hABCDE}); else passed++;
  endtask

  task automatic test_power();
    logic blocked_ack;
    blocked_ack = 1'b0;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    power = 1'b0; req1_valid = 1'b1;
    tick(); tick();
    mem_ready = 1'b1; mem_data_out = 20'h00777;
    tick();
    mem_ready = 1'b0;
    total++; if ({req0_done, rsp_data} !== {1'b1, 20'h00777})
      $display("FAIL power_inflight got %h exp %h", {req0_done, rsp_data}, {1'b1, 20'h00777}); else passed++;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (req1_ack || mem_execute) blocked_ack = 1'b1;
    end
    total++; if (blocked_ack !== 1'b0) $display("FAIL power_blocked got %b exp 0", blocked_ack); else passed++;
    power = 1'b1;
    tick();
    req1_valid = 1'b0;
    total++; if ({req1_ack, mem_execute} !== 2'b11) $display("FAIL power_resume got %b exp 11", {req1_ack, mem_execute}); else passed++;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total++; if (req1_done !== 1'b1) $display("FAIL power_resume_done got %b exp 1", req1_done); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    logic stray;
    stray = 1'b0;
    req1_valid = 1'b1; req1_addr0 = 16'h0033;
    tick();
    req1_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    total++; if (any_out !== 1'b0) $display("FAIL reset_async got %b exp 0", any_out); else passed++;
    mem_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (any_out) stray = 1'b1;
    end
    mem_ready = 1'b0;
    total++; if (stray !== 1'b0) $display("FAIL reset_no_done got %b exp 0", stray); else passed++;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if ({req0_ack, req1_ack} !== 2'b10) $display("FAIL reset_first_grant got %b exp 10", {req0_ack, req1_ack}); else passed++;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_ready_in_issue();
    logic stray;
    stray = 1'b0;
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    mem_ready = 1'b1; mem_data_out = 20'hBAD00;
    tick();
    mem_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (req1_done || req0_done) stray = 1'b1;
    end
    total++; if (stray !== 1'b0) $display("FAIL issue_ready_ignored got %b exp 0", stray); else passed++;
    mem_ready = 1'b1; mem_data_out = 20'h0600D;
    tick();
    mem_ready = 1'b0;
    total++; if ({req1_done, rsp_err, rsp_data} !== {2'b10, 20'h0600D})
      $display("FAIL issue_later_done got %h exp %h", {req1_done, rsp_err, rsp_data}, {2'b10, 20'h0600D}); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_timeout();
    test_power();
    test_reset_mid_wait();
    test_ready_in_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
